e_muldiv_unit: RTL

Execute-stage multiply/divide unit for the P7 pipeline. It consumes the E-stage multiply/divide control fields (`start`, `HI_En`, `LO_En`, `MAD_sel`) and the forwarded E-stage operands, and runs a fixed-latency multicycle operation. It holds the architectural HI/LO registers and drives `busy`, which the hazard unit combines with `start` and D-stage `ifMAD` to stall.

---
 rtl/e_muldiv_unit_pkg.sv | 79 +++++++
 rtl/e_muldiv_unit_if.sv | 29 ++
 rtl/e_muldiv_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/e_muldiv_unit_pkg.sv
// Shared constants and helpers for the E-stage multiply/divide unit.
// MAD_sel encodings and default latencies live here so the decoder,
// the hazard unit and the unit itself agree on the same values.
package e_muldiv_unit_pkg;

  localparam int DATA_W          = 32;
  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MAD_MULT  = 3'd0,
    MAD_MULTU = 3'd1,
    MAD_DIV   = 3'd2,
    MAD_DIVU  = 3'd3,
    MAD_MFHI  = 3'd4,
    MAD_MFLO  = 3'd5,
    MAD_MTHI  = 3'd6,
    MAD_MTLO  = 3'd7
  } mad_sel_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  // Result captured at launch and held until commit.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              wr;
  } mdu_result_t;

  function automatic logic mdu_is_div(input logic [2:0] sel);
    return (sel == MAD_DIV) || (sel == MAD_DIVU);
  endfunction

  // Full result of a mult/div op. Divide by zero leaves wr clear so the
  // architectural HI/LO keep their old values at completion.
  function automatic mdu_result_t mdu_compute(input logic [2:0]        sel,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    mdu_result_t       r;
    logic [2*DATA_W-1:0] prod;
    r    = '0;
    prod = '0;
    case (sel)
      MAD_MULT: begin
        prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        r.hi = prod[2*DATA_W-1:DATA_W];
        r.lo = prod[DATA_W-1:0];
        r.wr = 1'b1;
      end
      MAD_MULTU: begin
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        r.hi = prod[2*DATA_W-1:DATA_W];
        r.lo = prod[DATA_W-1:0];
        r.wr = 1'b1;
      end
      MAD_DIV: begin
        if (b != '0) begin
          r.lo = $signed(a) / $signed(b);
          r.hi = $signed(a) % $signed(b);
          r.wr = 1'b1;
        end
      end
      MAD_DIVU: begin
        if (b != '0) begin
          r.lo = a / b;
          r.hi = a % b;
          r.wr = 1'b1;
        end
      end
      default: ;  // not an arithmetic op: nothing to commit
    endcase
    return r;
  endfunction

endpackage

// File: rtl/e_muldiv_unit_if.sv
// Bundle between the E stage and the multiply/divide unit.
// master: E-stage control/operands out, busy/HI/LO/MAD_out in.
// slave: the unit side of the same signals.
interface e_muldiv_unit_if;
  import e_muldiv_unit_pkg::*;

  logic              start;
  logic [2:0]        MAD_sel;
  logic              HI_En;
  logic              LO_En;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              flush;
  logic              busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic [DATA_W-1:0] MAD_out;

  modport master (
    output start, MAD_sel, HI_En, LO_En, A, B, flush,
    input  busy, HI, LO, MAD_out
  );

  modport slave (
    input  start, MAD_sel, HI_En, LO_En, A, B, flush,
    output busy, HI, LO, MAD_out
  );

endinterface

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit holding architectural HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, commit on the edge busy drops;
// mthi/mtlo 1 cycle; MAD_out combinational. No backpressure: busy feeds the
// hazard unit, and start/HI_En/LO_En seen while busy are ignored.
// Ports: clk, reset (async, active-high), mdu (slave side of e_muldiv_unit_if).
module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  e_muldiv_unit_if.slave mdu
);

  mdu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] p_hi, p_lo;
  logic              p_wr;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              launch, done, mt_ok;
  mdu_result_t       res;

  // flush suppresses new side effects only; an op already in flight commits.
  assign launch = (state == S_IDLE) && mdu.start && !mdu.flush;
  assign done   = (state == S_BUSY) && (cnt == CNT_W'(1));
  // start wins over a simultaneous mthi/mtlo.
  assign mt_ok  = (state == S_IDLE) && !mdu.start && !mdu.flush;
  assign res    = mdu_compute(mdu.MAD_sel, mdu.A, mdu.B);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_BUSY;
      S_BUSY:  if (done)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mdu.busy    = (state == S_BUSY);
    mdu.MAD_out = '0;
    case (mdu.MAD_sel)
      MAD_MFHI: mdu.MAD_out = hi_q;
      MAD_MFLO: mdu.MAD_out = lo_q;
      default:  mdu.MAD_out = '0;
    endcase
  end

  assign mdu.HI = hi_q;
  assign mdu.LO = lo_q;

  // Latency counter and pending result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      p_wr <= 1'b0;
    end else if (launch) begin
      cnt  <= mdu_is_div(mdu.MAD_sel) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      p_hi <= res.hi;
      p_lo <= res.lo;
      p_wr <= res.wr;
    end else if (state == S_BUSY) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  // Architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (p_wr) begin
        hi_q <= p_hi;
        lo_q <= p_lo;
      end
    end else if (mt_ok) begin
      if (mdu.HI_En) hi_q <= mdu.A;
      if (mdu.LO_En) lo_q <= mdu.A;
    end
  end

endmodule
